// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: op encoding, FSM states,
// error causes and the request legality check.
package lsu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_SW  = 3'd1,
        OP_LB  = 3'd2,
        OP_LBU = 3'd3,
        OP_SB  = 3'd4
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL_OP = 2'd1;
    localparam logic [1:0] ERR_MISALIGNED = 2'd2;
    localparam logic [1:0] ERR_RANGE      = 2'd3;

    function automatic logic [1:0] err_cause(input logic [2:0]  op,
                                             input logic [15:0] ea,
                                             input logic [15:0] words);
        if (op > 3'd4)
            return ERR_ILLEGAL_OP;
        if ((op == OP_LW || op == OP_SW) && ea[0])
            return ERR_MISALIGNED;
        if ({1'b0, ea[15:1]} >= words)
            return ERR_RANGE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between the pipeline (master) and the LSU (slave).
interface lsu_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [OP_W-1:0] req_op;
    logic [15:0]     req_base;
    logic [15:0]     req_offset;
    logic [15:0]     req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [15:0]     rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_op, req_base, req_offset, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_base, req_offset, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// Byte extraction (sign/zero extend) and byte merge for one 16-bit word.
module lsu_byte_lane (
    input  logic [15:0] word,
    input  logic        lane,
    input  logic [7:0]  byte_in,
    input  logic        sign_ext,
    output logic [15:0] extracted,
    output logic [15:0] merged
);
    logic [7:0] sel;

    assign sel       = lane ? word[15:8] : word[7:0];
    assign extracted = sign_ext ? {{8{sel[7]}}, sel} : {8'h00, sel};
    assign merged    = lane ? {byte_in, word[7:0]} : {word[15:8], byte_in};
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit for a 16-bit word memory with byte access.
// state   | meaning
// IDLE    | ready for a request; operands captured on acceptance
// READ    | one-cycle memory read (loads, and SB before its merge)
// WRITE   | one-cycle memory write (SW data or SB merged word)
// RESP    | response held until rsp_ready
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_if.slave        bus,
    output logic        mem_wr_en,
    output logic [15:0] mem_wr_Addr,
    output logic [15:0] mem_wr_data,
    output logic        mem_read_en,
    output logic [15:0] mem_rd_Addr,
    input  logic [15:0] mem_rd_data
);
    localparam logic [15:0] WORDS_LIM = 16'(MEM_WORDS);

    lsu_state_e  state_q, state_d;
    logic [2:0]  op_q;
    logic [15:0] ea_q, wdata_q, merged_q, rdata_q;
    logic        err_q;
    logic [15:0] ea;
    logic        req_err;
    logic [15:0] lane_ext, lane_merged;

    assign ea      = bus.req_base + bus.req_offset;
    assign req_err = (err_cause(bus.req_op, ea, WORDS_LIM) != ERR_NONE);

    lsu_byte_lane u_lane (
        .word      (mem_rd_data),
        .lane      (ea_q[0]),
        .byte_in   (wdata_q[7:0]),
        .sign_ext  (op_q == OP_LB),
        .extracted (lane_ext),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // req_ready is gated by rst_n so it reads low for the whole reset window.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 16'h0000;
        bus.rsp_err   = 1'b0;
        mem_read_en   = 1'b0;
        mem_rd_Addr   = 16'h0000;
        mem_wr_en     = 1'b0;
        mem_wr_Addr   = 16'h0000;
        mem_wr_data   = 16'h0000;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = rst_n;
                if (bus.req_valid && rst_n) begin
                    if (req_err)
                        state_d = ST_RESP;
                    else if (bus.req_op == OP_SW)
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                mem_read_en = 1'b1;
                mem_rd_Addr = {1'b0, ea_q[15:1]};
                state_d     = (op_q == OP_SB) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                mem_wr_en   = 1'b1;
                mem_wr_Addr = {1'b0, ea_q[15:1]};
                mem_wr_data = (op_q == OP_SW) ? wdata_q : merged_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rdata_q;
                bus.rsp_err   = err_q;
                if (bus.rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // SB keeps the merged word from its READ cycle so WRITE needs no second read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 3'd0;
            ea_q     <= 16'h0000;
            wdata_q  <= 16'h0000;
            merged_q <= 16'h0000;
            rdata_q  <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && bus.req_valid) begin
                op_q    <= bus.req_op;
                ea_q    <= ea;
                wdata_q <= bus.req_wdata;
                err_q   <= req_err;
                rdata_q <= 16'h0000;
            end
            if (state_q == ST_READ) begin
                merged_q <= lane_merged;
                if (op_q != OP_SB)
                    rdata_q <= (op_q == OP_LW) ? mem_rd_data : lane_ext;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data memory and
// a response scoreboard.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 8;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if bus ();

    logic        mem_wr_en, mem_read_en;
    logic [15:0] mem_wr_Addr, mem_wr_data, mem_rd_Addr, mem_rd_data;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_Addr (mem_wr_Addr),
        .mem_wr_data (mem_wr_data),
        .mem_read_en (mem_read_en),
        .mem_rd_Addr (mem_rd_Addr),
        .mem_rd_data (mem_rd_data)
    );

    logic [15:0] mem [MEM_WORDS];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_addr = 3'd0;
    logic [15:0] pl_data = 16'h0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (mem_wr_en)
            mem[mem_wr_Addr[2:0]] <= mem_wr_data;
    end
    assign mem_rd_data = mem_read_en ? mem[mem_rd_Addr[2:0]] : 16'h0000;

    int n_checks = 0;
    int n_fails = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int overlap_cnt = 0;
    int idle_nz_cnt = 0;
    int rst_wr0 = 0;
    logic [15:0] last_rd_addr = 16'h0;
    logic [15:0] last_wr_addr = 16'h0;
    logic [15:0] last_wr_data = 16'h0;
    exp_t sb_q[$];

    always @(negedge clk) begin
        if (mem_read_en) begin
            rd_cnt++;
            last_rd_addr = mem_rd_Addr;
        end
        if (mem_wr_en) begin
            wr_cnt++;
            last_wr_addr = mem_wr_Addr;
            last_wr_data = mem_wr_data;
        end
        if (mem_read_en && mem_wr_en)
            overlap_cnt++;
        if (!mem_read_en && mem_rd_Addr != 16'h0)
            idle_nz_cnt++;
        if (!mem_wr_en && (mem_wr_Addr != 16'h0 || mem_wr_data != 16'h0))
            idle_nz_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] base,
                         input logic [15:0] off, input logic [15:0] wdata,
                         input logic [15:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_rd, input int exp_wr, input int stall);
        int k;
        int rd0;
        int wr0;
        exp_t e;
        @(negedge clk);
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_base = base;
        bus.req_offset = off;
        bus.req_wdata = wdata;
        bus.rsp_ready = (stall == 0);
        sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(posedge clk);
        #1;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        bus.req_valid = 1'b0;
        bus.req_op = 3'($urandom);
        bus.req_base = 16'($urandom);
        bus.req_offset = 16'($urandom);
        bus.req_wdata = 16'($urandom);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.rsp_valid && k < 10);
        check_val({tag, "_latency"}, 32'(k), 32'(exp_lat));
        e = '{rdata: 16'hDEAD, err: 1'b1};
        if (sb_q.size() > 0)
            e = sb_q.pop_front();
        check_val({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(e.rdata));
        check_val({tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_val({tag, "_stall_valid"}, 32'(bus.rsp_valid), 32'd1);
            check_val({tag, "_stall_rdata"}, 32'(bus.rsp_rdata), 32'(e.rdata));
            check_val({tag, "_stall_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val({tag, "_rsp_done"}, 32'(bus.rsp_valid), 32'd0);
        check_val({tag, "_rd_pulses"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check_val({tag, "_wr_pulses"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op = 3'd0;
        bus.req_base = 16'h0;
        bus.req_offset = 16'h0;
        bus.req_wdata = 16'h0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check_val("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_val("rst_mem_en", 32'({mem_read_en, mem_wr_en}), 32'd0);
        check_val("rst_mem_bus", 32'(mem_rd_Addr | mem_wr_Addr | mem_wr_data), 32'd0);

        for (int i = 0; i < MEM_WORDS; i++)
            preload(3'(i), 16'h0000);
        preload(3'd3, 16'hBEEF);
        preload(3'd2, 16'h1234);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        do_op("lw_ea6", OP_LW, 16'h0004, 16'h0002, 16'h0, 16'hBEEF, 1'b0, 2, 1, 0, 0);
        check_val("lw_ea6_rd_addr", 32'(last_rd_addr), 32'd3);

        do_op("sb_ea5", OP_SB, 16'h0005, 16'h0000, 16'h00A5, 16'h0000, 1'b0, 3, 1, 1, 0);
        check_val("sb_ea5_rd_addr", 32'(last_rd_addr), 32'd2);
        check_val("sb_ea5_wr_addr", 32'(last_wr_addr), 32'd2);
        check_val("sb_ea5_wr_data", 32'(last_wr_data), 32'hA534);

        do_op("lb_ea5", OP_LB, 16'h0000, 16'h0005, 16'h0, 16'hFFA5, 1'b0, 2, 1, 0, 0);
        do_op("lbu_ea5", OP_LBU, 16'h0006, 16'hFFFF, 16'h0, 16'h00A5, 1'b0, 2, 1, 0, 0);
        do_op("lb_ea6", OP_LB, 16'h0006, 16'h0000, 16'h0, 16'hFFEF, 1'b0, 2, 1, 0, 0);
        do_op("lbu_ea7", OP_LBU, 16'h0007, 16'h0000, 16'h0, 16'h00BE, 1'b0, 2, 1, 0, 0);

        do_op("err_lw_misal", OP_LW, 16'h0003, 16'h0000, 16'h0, 16'h0000, 1'b1, 1, 0, 0, 0);
        do_op("err_sw_range", OP_SW, 16'h0010, 16'h0000, 16'h1111, 16'h0000, 1'b1, 1, 0, 0, 0);
        do_op("err_op6", 3'd6, 16'h0002, 16'h0000, 16'h0, 16'h0000, 1'b1, 1, 0, 0, 0);

        do_op("sw_wrap", OP_SW, 16'h0002, 16'hFFFE, 16'h5A5A, 16'h0000, 1'b0, 2, 0, 1, 0);
        check_val("sw_wrap_wr_addr", 32'(last_wr_addr), 32'd0);
        check_val("sw_wrap_mem0", 32'(mem[0]), 32'h5A5A);
        do_op("lw_ea0", OP_LW, 16'h0000, 16'h0000, 16'h0, 16'h5A5A, 1'b0, 2, 1, 0, 0);

        do_op("lw_stall", OP_LW, 16'h0006, 16'h0000, 16'h0, 16'hBEEF, 1'b0, 2, 1, 0, 5);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = OP_SB;
        bus.req_base = 16'h0005;
        bus.req_offset = 16'h0000;
        bus.req_wdata = 16'h0077;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_wr0 = wr_cnt;
        @(negedge clk);
        check_val("rst_sb_read_cycle", 32'(mem_read_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_sb_req_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_sb_rsp", 32'({bus.rsp_valid, bus.rsp_err}), 32'd0);
        check_val("rst_sb_rdata", 32'(bus.rsp_rdata), 32'd0);
        check_val("rst_sb_mem_en", 32'({mem_read_en, mem_wr_en}), 32'd0);
        check_val("rst_sb_mem_bus", 32'(mem_rd_Addr | mem_wr_Addr | mem_wr_data), 32'd0);
        repeat (3) @(negedge clk);
        check_val("rst_sb_no_wr", 32'(mem_wr_en), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_sb_ready_back", 32'(bus.req_ready), 32'd1);
        check_val("rst_sb_mem2", 32'(mem[2]), 32'hA534);
        check_val("rst_sb_wr_cnt", 32'(wr_cnt - rst_wr0), 32'd0);

        do_op("lw_after_rst", OP_LW, 16'h0004, 16'h0000, 16'h0, 16'hA534, 1'b0, 2, 1, 0, 0);

        check_val("rd_wr_overlap", 32'(overlap_cnt), 32'd0);
        check_val("idle_mem_bus_nonzero", 32'(idle_nz_cnt), 32'd0);
        check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 8: number of 16-bit words in the attached data memory (power of two, 2..32768).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 req_valid  input  1  pipeline presents a memory operation.
REQ-005 req_ready  output  1  unit can accept a request; a transfer occurs when req_valid and req_ready are both high at a rising edge.
REQ-006 req_op  input  3  operation: LW=0, SW=1, LB=2, LBU=3, SB=4; codes 5-7 are illegal.
REQ-007 req_base  input  16  base register value.
REQ-008 req_offset  input  16  two's-complement offset.
REQ-009 req_wdata  input  16  store data; SB uses bits [7:0].
REQ-010 rsp_valid  output  1  response is available.
REQ-011 rsp_ready  input  1  consumer accepts the response; the response completes on valid and ready.
REQ-012 rsp_rdata  output  16  load result; 0 for stores and errors.
REQ-013 rsp_err  output  1  the operation was rejected with no memory side effect.
REQ-014 mem_wr_en, mem_wr_Addr[15:0], mem_wr_data[15:0]  output  write port to the data memory (1-cycle write).
REQ-015 mem_read_en, mem_rd_Addr[15:0]  output; mem_rd_data[15:0]  input  read port (combinational read, data valid in the same cycle).

Function
REQ-016 Effective byte address EA = (req_base + req_offset) mod 2^16, captured at request acceptance. Word address WA = EA[15:1]; byte lane = EA[0] (0 = bits [7:0], 1 = bits [15:8]).
REQ-017 FSM states: IDLE, READ, WRITE, RESP. req_ready = 1 only in IDLE.
REQ-018 Transitions on acceptance in IDLE: LW/LB/LBU/SB go to READ; SW goes to WRITE; an error goes to RESP.
REQ-019 Error conditions:
  - illegal op;
  - LW/SW with EA[0]=1;
  - WA >= MEM_WORDS.
  An error drives no mem_read_en or mem_wr_en pulse and produces rsp_err=1 with rsp_rdata=0.
REQ-020 READ lasts exactly one cycle: mem_read_en=1, mem_rd_Addr=WA, mem_rd_data captured.
  - Loads then go to RESP.
  - SB then goes to WRITE.
REQ-021 WRITE lasts exactly one cycle: mem_wr_en=1, mem_wr_Addr=WA, then go to RESP.
  - SW writes req_wdata.
  - SB writes the captured word with the selected lane replaced by req_wdata[7:0].
REQ-022 Load results:
  - LW returns the word.
  - LB returns the selected byte sign-extended to 16 bits.
  - LBU returns the selected byte zero-extended.
REQ-023 RESP: rsp_valid=1 and rsp_rdata/rsp_err are held stable until rsp_ready; then go to IDLE. rsp_ready is ignored outside RESP.
REQ-024 Latency from acceptance edge to first rsp_valid cycle: LW/LB/LBU 2, SW 2, SB 3, error 1. Back-to-back throughput is one request per (latency+1) cycles with rsp_ready tied high.
REQ-025 mem_read_en and mem_wr_en are never high in the same cycle. Memory address and data outputs are 0 whenever their enable is low.
REQ-026 Changes on the request inputs after acceptance have no effect; all operands are registered.

Reset
REQ-027 While rst_n=0: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and all mem_* outputs 0.
REQ-028 req_ready rises in the first cycle after rst_n deasserts.
REQ-029 Reset asserted mid-operation aborts the operation. No write is issued after reset, and a pending response is discarded.

Structure
REQ-030 Shared package lsu_pkg holds:
  - the op encoding enum (LW, SW, LB, LBU, SB);
  - the FSM state enum;
  - the error-cause constants.
REQ-031 Byte extract/merge logic sits in one combinational sub-module, lsu_byte_lane (inputs: word, lane, byte, signed flag; outputs: extracted 16-bit value, merged word).
REQ-032 Target size is 120-400 lines of RTL, excluding the package.

Verification (bench models the data memory: 1-cycle write, combinational read)
REQ-033 LW: preload mem[3]=0xBEEF; LW base=0x0004, offset=0x0002 (EA=6) -> mem_read_en pulse with mem_rd_Addr=3, rsp_valid 2 cycles after acceptance, rsp_rdata=0xBEEF, rsp_err=0.
REQ-034 SB then LB/LBU:
  - Start from mem[2]=0x1234; SB EA=5, wdata=0x00A5 -> read pulse at address 2, then write pulse with mem_wr_data=0xA534, rsp_valid at cycle 3.
  - LB EA=5 then returns 0xFFA5.
  - LBU EA=5 then returns 0x00A5.
REQ-035 Errors: LW EA=0x0003 (misaligned), SW EA=0x0010 (WA=8), and op=6 -> each gives rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after acceptance, and no mem enable pulse.
REQ-036 Offset wrap: base=0x0002, offset=0xFFFE -> EA=0; SW wdata=0x5A5A writes mem[0]=0x5A5A.
REQ-037 Backpressure: hold rsp_ready=0 for 5 cycles during LW -> rsp_valid/rsp_rdata stay stable, req_ready stays 0, and no extra memory pulses occur.
REQ-038 Reset mid-SB: assert rst_n=0 during the READ cycle -> no mem_wr_en pulse, the memory word is unchanged, and all outputs are 0 during reset.
